// File: rtl/led_status_sequencer_if.sv
// Signal bundle between an event-producing master and the shared status-LED sequencer.
interface led_status_sequencer_if;
   logic [2:0] req;
   logic       clr_err;
   logic       led;
   logic       busy;
   logic [2:0] grant;
   logic [1:0] active_id;

   modport master (
      output req,
      output clr_err,
      input  led,
      input  busy,
      input  grant,
      input  active_id
   );

   modport slave (
      input  req,
      input  clr_err,
      output led,
      output busy,
      output grant,
      output active_id
   );
endinterface

// File: rtl/led_status_sequencer.sv
// Arbitrates three latched event sources onto one LED, playing a per-source blink burst then a dark gap.
// Optional LED_STATUS_ERR_STICKY_EN: pending[2] survives its grant and is cleared only by clr_err.
module led_status_sequencer #(
   parameter logic [31:0] CLOCK_FREQUENCY = 32'd33_000_000,
   parameter logic [31:0] BLINK_FREQUENCY = 32'd2,
   parameter logic [3:0]  BLINKS0         = 4'd1,
   parameter logic [3:0]  BLINKS1         = 4'd2,
   parameter logic [3:0]  BLINKS2         = 4'd3,
   parameter logic [3:0]  GAP_PHASES      = 4'd2
) (
   input  logic                  clk,
   input  logic                  rst,
   led_status_sequencer_if.slave bus
);

   localparam logic [31:0] HALF    = CLOCK_FREQUENCY / (BLINK_FREQUENCY * 32'd2);
   localparam logic [31:0] GAP_LEN = {28'd0, GAP_PHASES} * HALF;

   if (HALF < 32'd1) begin : g_bad_half
      $error("led_status_sequencer: HALF must be at least 1");
   end
   if (BLINKS0 == 4'd0 || BLINKS1 == 4'd0 || BLINKS2 == 4'd0) begin : g_bad_blinks
      $error("led_status_sequencer: every BLINKSn must be non-zero");
   end
   if (GAP_PHASES == 4'd0) begin : g_bad_gap
      $error("led_status_sequencer: GAP_PHASES must be non-zero");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ON,
      ST_OFF,
      ST_GAP
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  pending_q, pending_d;
   logic [31:0] phase_cnt_q, phase_cnt_d;
   logic [3:0]  blink_cnt_q, blink_cnt_d;
   logic        led_q, led_d;
   logic        busy_q, busy_d;
   logic [2:0]  grant_q, grant_d;
   logic [1:0]  active_id_q, active_id_d;
   logic [2:0]  clear_mask;
   logic [3:0]  blinks_cur;

`ifndef LED_STATUS_ERR_STICKY_EN
   logic unused_clr_err;
   assign unused_clr_err = bus.clr_err;
`endif

   always_comb begin
      case (active_id_q)
         2'd1:    blinks_cur = BLINKS1;
         2'd2:    blinks_cur = BLINKS2;
         default: blinks_cur = BLINKS0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      phase_cnt_d = phase_cnt_q;
      blink_cnt_d = blink_cnt_q;
      led_d       = led_q;
      grant_d     = '0;
      active_id_d = active_id_q;

      unique case (state_q)
         ST_IDLE: begin
            if (pending_q != '0) begin
               state_d     = ST_ON;
               led_d       = 1'b1;
               phase_cnt_d = '0;
               blink_cnt_d = '0;
               if (pending_q[2]) begin
                  grant_d     = 3'b100;
                  active_id_d = 2'd2;
               end else if (pending_q[1]) begin
                  grant_d     = 3'b010;
                  active_id_d = 2'd1;
               end else begin
                  grant_d     = 3'b001;
                  active_id_d = 2'd0;
               end
            end
         end
         ST_ON: begin
            if (phase_cnt_q == HALF - 32'd1) begin
               state_d     = ST_OFF;
               led_d       = 1'b0;
               phase_cnt_d = '0;
            end else begin
               phase_cnt_d = phase_cnt_q + 32'd1;
            end
         end
         ST_OFF: begin
            if (phase_cnt_q == HALF - 32'd1) begin
               phase_cnt_d = '0;
               if (blink_cnt_q == blinks_cur - 4'd1) begin
                  state_d = ST_GAP;
               end else begin
                  state_d     = ST_ON;
                  led_d       = 1'b1;
                  blink_cnt_d = blink_cnt_q + 4'd1;
               end
            end else begin
               phase_cnt_d = phase_cnt_q + 32'd1;
            end
         end
         ST_GAP: begin
            if (phase_cnt_q == GAP_LEN - 32'd1) begin
               state_d     = ST_IDLE;
               phase_cnt_d = '0;
               blink_cnt_d = '0;
               active_id_d = 2'd0;
            end else begin
               phase_cnt_d = phase_cnt_q + 32'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);

      // A new req on the granting edge re-arms the source, so it replays exactly once.
      clear_mask = grant_d;
`ifdef LED_STATUS_ERR_STICKY_EN
      clear_mask[2] = 1'b0;
`endif
      pending_d = (pending_q & ~clear_mask) | bus.req;
`ifdef LED_STATUS_ERR_STICKY_EN
      if (bus.clr_err) begin
         pending_d[2] = bus.req[2];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         phase_cnt_q <= '0;
         blink_cnt_q <= '0;
         led_q       <= 1'b0;
         busy_q      <= 1'b0;
         grant_q     <= '0;
         active_id_q <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         phase_cnt_q <= phase_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         led_q       <= led_d;
         busy_q      <= busy_d;
         grant_q     <= grant_d;
         active_id_q <= active_id_d;
      end
   end

   assign bus.led       = led_q;
   assign bus.busy      = busy_q;
   assign bus.grant     = grant_q;
   assign bus.active_id = active_id_q;

endmodule

// File: tb/tb_led_status_sequencer.sv
// Bench for led_status_sequencer: burst-timeline reference model compared every cycle, plus directed scenario totals.
module tb_led_status_sequencer;

   localparam int unsigned HALF = 10;
   localparam int unsigned GAP  = 2;
`ifdef LED_STATUS_ERR_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   led_status_sequencer_if bus_if();

   led_status_sequencer #(
      .CLOCK_FREQUENCY(32'd40),
      .BLINK_FREQUENCY(32'd2),
      .BLINKS0        (4'd1),
      .BLINKS1        (4'd2),
      .BLINKS2        (4'd3),
      .GAP_PHASES     (4'd2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int unsigned blinks(input logic [1:0] id);
      case (id)
         2'd1:    return 2;
         2'd2:    return 3;
         default: return 1;
      endcase
   endfunction

   function automatic int unsigned burst_len(input logic [1:0] id);
      return (2 * blinks(id) + GAP) * HALF;
   endfunction

   // Reference: a burst is a timeline of length burst_len starting at the grant edge.
   logic [2:0]  m_pend = '0, n_pend;
   logic        m_run = 1'b0, n_run;
   logic [1:0]  m_id = '0, n_id;
   int unsigned m_t = 0, n_t;
   logic [2:0]  m_grant = '0, n_grant;

   always_comb begin
      n_pend  = m_pend;
      n_run   = m_run;
      n_id    = m_id;
      n_t     = m_t;
      n_grant = '0;
      if (m_run) begin
         if (m_t + 1 == burst_len(m_id)) begin
            n_run = 1'b0;
            n_id  = 2'd0;
            n_t   = 0;
         end else begin
            n_t = m_t + 1;
         end
      end else if (m_pend != 3'b000) begin
         n_run   = 1'b1;
         n_t     = 0;
         n_id    = m_pend[2] ? 2'd2 : (m_pend[1] ? 2'd1 : 2'd0);
         n_grant = 3'b001 << n_id;
         if (!(STICKY && n_id == 2'd2)) n_pend = n_pend & ~n_grant;
      end
      n_pend = n_pend | bus_if.req;
      if (STICKY && bus_if.clr_err) n_pend[2] = bus_if.req[2];
      if (rst) begin
         n_pend  = '0;
         n_run   = 1'b0;
         n_id    = '0;
         n_t     = 0;
         n_grant = '0;
      end
   end

   always @(posedge clk) begin
      m_pend  <= n_pend;
      m_run   <= n_run;
      m_id    <= n_id;
      m_t     <= n_t;
      m_grant <= n_grant;
   end

   logic       e_led, e_busy;
   logic [1:0] e_id;
   always_comb begin
      e_busy = m_run;
      e_id   = m_run ? m_id : 2'd0;
      e_led  = m_run && (m_t < 2 * blinks(m_id) * HALF) && ((m_t / HALF) % 2 == 0);
   end

   int unsigned cnt_led = 0, cnt_busy = 0, cnt_g0 = 0, cnt_g1 = 0, cnt_g2 = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("led", {31'd0, bus_if.led}, {31'd0, e_led});
         check("busy", {31'd0, bus_if.busy}, {31'd0, e_busy});
         check("grant", {29'd0, bus_if.grant}, {29'd0, m_grant});
         check("active_id", {30'd0, bus_if.active_id}, {30'd0, e_id});
         cnt_led  <= cnt_led + {31'd0, bus_if.led === 1'b1};
         cnt_busy <= cnt_busy + {31'd0, bus_if.busy === 1'b1};
         cnt_g0   <= cnt_g0 + {31'd0, bus_if.grant[0] === 1'b1};
         cnt_g1   <= cnt_g1 + {31'd0, bus_if.grant[1] === 1'b1};
         cnt_g2   <= cnt_g2 + {31'd0, bus_if.grant[2] === 1'b1};
      end
   end

   int unsigned s_led, s_busy, s_g0, s_g1, s_g2;

   task automatic snap();
      s_led  = cnt_led;
      s_busy = cnt_busy;
      s_g0   = cnt_g0;
      s_g1   = cnt_g1;
      s_g2   = cnt_g2;
   endtask

   task automatic check_deltas(input string tag, input int unsigned g0, input int unsigned g1,
                               input int unsigned g2, input int unsigned led, input int unsigned busy);
      check({tag, "_grant0"}, cnt_g0 - s_g0, g0);
      check({tag, "_grant1"}, cnt_g1 - s_g1, g1);
      check({tag, "_grant2"}, cnt_g2 - s_g2, g2);
      check({tag, "_led_cycles"}, cnt_led - s_led, led);
      check({tag, "_busy_cycles"}, cnt_busy - s_busy, busy);
   endtask

   task automatic pulse_req(input logic [2:0] v);
      bus_if.req = v;
      @(negedge clk);
      bus_if.req = '0;
   endtask

   task automatic wait_quiet(input string tag);
      int quiet = 0;
      int cyc = 0;
      while (quiet < 3 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         quiet = (bus_if.busy === 1'b0) ? quiet + 1 : 0;
      end
      check({tag, "_quiet_reached"}, {31'd0, quiet >= 3}, 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst            = 1'b1;
      bus_if.req     = 3'b111;
      bus_if.clr_err = 1'b0;

      // 1: reset holds everything quiet even with all requests high.
      @(negedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_led", {31'd0, bus_if.led}, 32'd0);
      check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
      check("rst_grant", {29'd0, bus_if.grant}, 32'd0);
      snap();
      rst = 1'b0;
      @(negedge clk);
      n = 1;
      bus_if.req = '0;
      while (bus_if.grant === 3'b000 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("release_to_grant_edges", n, 32'd2);
      check("first_grant_is_src2", {29'd0, bus_if.grant}, 32'd4);
      bus_if.clr_err = 1'b1;
      @(negedge clk);
      bus_if.clr_err = 1'b0;
      wait_quiet("t1");
      check_deltas("t1", 1, 1, 1, 60, 180);

      // 2: single low-priority event.
      snap();
      pulse_req(3'b001);
      wait_quiet("t2");
      check_deltas("t2", 1, 0, 0, 10, 40);

      // 3: simultaneous events served highest first.
      snap();
      bus_if.req = 3'b101;
      @(negedge clk);
      bus_if.req     = '0;
      bus_if.clr_err = 1'b1;
      @(negedge clk);
      bus_if.clr_err = 1'b0;
      wait_quiet("t3");
      check_deltas("t3", 1, 0, 1, 40, 120);

      // 4: repeated pulses during a burst coalesce into one replay.
      snap();
      pulse_req(3'b010);
      repeat (5) @(negedge clk);
      pulse_req(3'b010);
      repeat (10) @(negedge clk);
      pulse_req(3'b010);
      repeat (15) @(negedge clk);
      pulse_req(3'b010);
      wait_quiet("t4");
      check_deltas("t4", 0, 2, 0, 40, 120);

      // 5: reset mid-ON aborts the burst and forgets it.
      pulse_req(3'b001);
      n = 0;
      while (bus_if.grant === 3'b000 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t5_grant_seen", {29'd0, bus_if.grant}, 32'd1);
      repeat (4) @(negedge clk);
      check("t5_led_before_rst", {31'd0, bus_if.led}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_led_after_rst", {31'd0, bus_if.led}, 32'd0);
      check("t5_busy_after_rst", {31'd0, bus_if.busy}, 32'd0);
      snap();
      repeat (100) @(negedge clk);
      check_deltas("t5", 0, 0, 0, 0, 0);

      // 6: error event with a late clr_err.
      snap();
      pulse_req(3'b100);
      repeat (199) @(negedge clk);
      bus_if.clr_err = 1'b1;
      @(negedge clk);
      bus_if.clr_err = 1'b0;
      wait_quiet("t6");
      if (STICKY) check_deltas("t6", 0, 0, 3, 90, 240);
      else        check_deltas("t6", 0, 0, 1, 30, 80);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
